// File: rtl/alu_rs.sv
// ---------------------------------------------------------------------------
// alu_rs : reservation station in front of the ALU of the Tomasulo core.
//
// Holds issued ALU / branch / jump ops until both source operands are known.
// Missing operands are snooped from the two CDB broadcasts (ALU result bus
// and LSB result bus). One ready op per cycle is sent to the ALU.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (0 = freeze), clr_in (flush)
//   issue_*      : op from the issue stage (opcode, rd tag, Qj/Qk, Vj/Vk,
//                  imm, pc)
//   alu_cdb_*    : ALU result broadcast (flg, tag, val)
//   lsb_cdb_*    : LSB result broadcast (flg, tag, val)
//   rs_full      : every entry busy (combinational from registered state)
//   run_flg, rd_fr, Vj, Vk, imm, pc, opcode : registered dispatch to the ALU
//
// Handshakes
//   Issue   : an op is accepted at a rising edge where issue_flg && rdy_in &&
//             !clr_in && !rs_full. rs_full is the issuer's (inverted) ready;
//             an op offered while rs_full=1 is dropped.
//   Dispatch: run_flg is a one-cycle valid with no back-pressure; the ALU
//             accepts every op presented. Other outputs hold between ops.
// ---------------------------------------------------------------------------
module alu_rs #(
    parameter int RS_SZ = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clr_in,
    input  logic             issue_flg,
    input  logic [3:0]       issue_opcode,
    input  logic [TAG_W-1:0] issue_rd,
    input  logic             issue_Qj_busy,
    input  logic             issue_Qk_busy,
    input  logic [TAG_W-1:0] issue_Qj,
    input  logic [TAG_W-1:0] issue_Qk,
    input  logic [31:0]      issue_Vj,
    input  logic [31:0]      issue_Vk,
    input  logic [31:0]      issue_imm,
    input  logic [31:0]      issue_pc,
    input  logic             alu_cdb_flg,
    input  logic [TAG_W-1:0] alu_cdb_tag,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_flg,
    input  logic [TAG_W-1:0] lsb_cdb_tag,
    input  logic [31:0]      lsb_cdb_val,
    output logic             rs_full,
    output logic             run_flg,
    output logic [TAG_W-1:0] rd_fr,
    output logic [31:0]      Vj,
    output logic [31:0]      Vk,
    output logic [31:0]      imm,
    output logic [31:0]      pc,
    output logic [3:0]       opcode
);

    localparam int IDX_W = $clog2(RS_SZ);

    // Entry control (reset) and payload (no reset; only meaningful while busy)
    logic [RS_SZ-1:0] r_busy;
    logic [RS_SZ-1:0] r_qj_busy;
    logic [RS_SZ-1:0] r_qk_busy;
    logic [3:0]       r_op  [RS_SZ];
    logic [TAG_W-1:0] r_rd  [RS_SZ];
    logic [TAG_W-1:0] r_qj  [RS_SZ];
    logic [TAG_W-1:0] r_qk  [RS_SZ];
    logic [31:0]      r_vj  [RS_SZ];
    logic [31:0]      r_vk  [RS_SZ];
    logic [31:0]      r_imm [RS_SZ];
    logic [31:0]      r_pc  [RS_SZ];

    // Dispatch output registers
    logic             r_run_flg;
    logic [TAG_W-1:0] r_rd_fr;
    logic [31:0]      r_vj_out;
    logic [31:0]      r_vk_out;
    logic [31:0]      r_imm_out;
    logic [31:0]      r_pc_out;
    logic [3:0]       r_opcode;

    logic             w_full;
    logic             w_step;
    logic             w_issue;
    logic             w_disp;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_disp_idx;
    logic [RS_SZ-1:0] w_ready;
    logic [RS_SZ-1:0] w_cap_j;
    logic [RS_SZ-1:0] w_cap_k;
    logic [31:0]      w_cap_j_val [RS_SZ];
    logic [31:0]      w_cap_k_val [RS_SZ];
    logic             w_in_qj_busy;
    logic             w_in_qk_busy;
    logic [31:0]      w_in_vj;
    logic [31:0]      w_in_vk;
    logic [RS_SZ-1:0] w_busy_nxt;
    logic [RS_SZ-1:0] w_qj_busy_nxt;
    logic [RS_SZ-1:0] w_qk_busy_nxt;

    assign w_full  = &r_busy;
    assign w_ready = r_busy & ~r_qj_busy & ~r_qk_busy;
    assign w_step  = rdy_in & ~clr_in;
    assign w_issue = issue_flg & ~w_full;

    // Lowest free and lowest ready entries. Scanning downwards lets the
    // lowest index overwrite any higher hit.
    always_comb begin
        w_free_idx = '0;
        w_disp_idx = '0;
        w_disp     = 1'b0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_disp_idx = IDX_W'(i);
                w_disp     = 1'b1;
            end
        end
    end

    // CDB snoop for waiting operands; the ALU bus wins if both buses match.
    always_comb begin
        for (int i = 0; i < RS_SZ; i++) begin
            w_cap_j[i]     = 1'b0;
            w_cap_j_val[i] = alu_cdb_val;
            w_cap_k[i]     = 1'b0;
            w_cap_k_val[i] = alu_cdb_val;
            if (r_busy[i] && r_qj_busy[i]) begin
                if (alu_cdb_flg && alu_cdb_tag == r_qj[i]) begin
                    w_cap_j[i] = 1'b1;
                end else if (lsb_cdb_flg && lsb_cdb_tag == r_qj[i]) begin
                    w_cap_j[i]     = 1'b1;
                    w_cap_j_val[i] = lsb_cdb_val;
                end
            end
            if (r_busy[i] && r_qk_busy[i]) begin
                if (alu_cdb_flg && alu_cdb_tag == r_qk[i]) begin
                    w_cap_k[i] = 1'b1;
                end else if (lsb_cdb_flg && lsb_cdb_tag == r_qk[i]) begin
                    w_cap_k[i]     = 1'b1;
                    w_cap_k_val[i] = lsb_cdb_val;
                end
            end
        end
    end

    // Issue-time bypass: an operand produced on a CDB in the issue cycle
    // would otherwise be missed, since the entry is not yet busy to snoop.
    always_comb begin
        w_in_qj_busy = issue_Qj_busy;
        w_in_vj      = issue_Vj;
        w_in_qk_busy = issue_Qk_busy;
        w_in_vk      = issue_Vk;
        if (issue_Qj_busy) begin
            if (alu_cdb_flg && alu_cdb_tag == issue_Qj) begin
                w_in_qj_busy = 1'b0;
                w_in_vj      = alu_cdb_val;
            end else if (lsb_cdb_flg && lsb_cdb_tag == issue_Qj) begin
                w_in_qj_busy = 1'b0;
                w_in_vj      = lsb_cdb_val;
            end
        end
        if (issue_Qk_busy) begin
            if (alu_cdb_flg && alu_cdb_tag == issue_Qk) begin
                w_in_qk_busy = 1'b0;
                w_in_vk      = alu_cdb_val;
            end else if (lsb_cdb_flg && lsb_cdb_tag == issue_Qk) begin
                w_in_qk_busy = 1'b0;
                w_in_vk      = lsb_cdb_val;
            end
        end
    end

    // Next control state for a normal (non-flush) cycle. The issued entry is
    // non-busy pre-edge, so it never collides with dispatch or capture.
    always_comb begin
        w_busy_nxt    = r_busy;
        w_qj_busy_nxt = r_qj_busy & ~w_cap_j;
        w_qk_busy_nxt = r_qk_busy & ~w_cap_k;
        if (w_disp) begin
            w_busy_nxt[w_disp_idx] = 1'b0;
        end
        if (w_issue) begin
            w_busy_nxt[w_free_idx]    = 1'b1;
            w_qj_busy_nxt[w_free_idx] = w_in_qj_busy;
            w_qk_busy_nxt[w_free_idx] = w_in_qk_busy;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy    <= '0;
            r_qj_busy <= '0;
            r_qk_busy <= '0;
            r_run_flg <= 1'b0;
            r_rd_fr   <= '0;
            r_vj_out  <= '0;
            r_vk_out  <= '0;
            r_imm_out <= '0;
            r_pc_out  <= '0;
            r_opcode  <= '0;
        end else if (rdy_in) begin
            if (clr_in) begin
                r_busy    <= '0;
                r_run_flg <= 1'b0;
            end else begin
                r_busy    <= w_busy_nxt;
                r_qj_busy <= w_qj_busy_nxt;
                r_qk_busy <= w_qk_busy_nxt;
                r_run_flg <= w_disp;
                if (w_disp) begin
                    r_rd_fr   <= r_rd[w_disp_idx];
                    r_vj_out  <= r_vj[w_disp_idx];
                    r_vk_out  <= r_vk[w_disp_idx];
                    r_imm_out <= r_imm[w_disp_idx];
                    r_pc_out  <= r_pc[w_disp_idx];
                    r_opcode  <= r_op[w_disp_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_step) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (w_cap_j[i]) begin
                    r_vj[i] <= w_cap_j_val[i];
                end
                if (w_cap_k[i]) begin
                    r_vk[i] <= w_cap_k_val[i];
                end
            end
            if (w_issue) begin
                r_op[w_free_idx]  <= issue_opcode;
                r_rd[w_free_idx]  <= issue_rd;
                r_qj[w_free_idx]  <= issue_Qj;
                r_qk[w_free_idx]  <= issue_Qk;
                r_vj[w_free_idx]  <= w_in_vj;
                r_vk[w_free_idx]  <= w_in_vk;
                r_imm[w_free_idx] <= issue_imm;
                r_pc[w_free_idx]  <= issue_pc;
            end
        end
    end

    assign rs_full = w_full;
    assign run_flg = r_run_flg;
    assign rd_fr   = r_rd_fr;
    assign Vj      = r_vj_out;
    assign Vk      = r_vk_out;
    assign imm     = r_imm_out;
    assign pc      = r_pc_out;
    assign opcode  = r_opcode;

endmodule

// File: tb/tb_alu_rs.sv
// ---------------------------------------------------------------------------
// tb_alu_rs : self-checking bench for alu_rs.
// Directed scenario tasks with fixed expectations, then a randomized run
// compared against a slot-level behavioural model of the station.
// ---------------------------------------------------------------------------
module tb_alu_rs;

    localparam int RS_SZ = 8;
    localparam int TAG_W = 5;
    localparam int PKT_W = TAG_W + 4 + 128;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef struct {
        bit               busy;
        logic [3:0]       op;
        logic [TAG_W-1:0] rd;
        bit               jb;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vj;
        bit               kb;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vk;
        logic [31:0]      imm;
        logic [31:0]      pc;
    } ent_t;

    logic             clk_in;
    logic             rst_in;
    logic             rdy_in;
    logic             clr_in;
    logic             issue_flg;
    logic [3:0]       issue_opcode;
    logic [TAG_W-1:0] issue_rd;
    logic             issue_Qj_busy;
    logic             issue_Qk_busy;
    logic [TAG_W-1:0] issue_Qj;
    logic [TAG_W-1:0] issue_Qk;
    logic [31:0]      issue_Vj;
    logic [31:0]      issue_Vk;
    logic [31:0]      issue_imm;
    logic [31:0]      issue_pc;
    logic             alu_cdb_flg;
    logic [TAG_W-1:0] alu_cdb_tag;
    logic [31:0]      alu_cdb_val;
    logic             lsb_cdb_flg;
    logic [TAG_W-1:0] lsb_cdb_tag;
    logic [31:0]      lsb_cdb_val;
    logic             rs_full;
    logic             run_flg;
    logic [TAG_W-1:0] rd_fr;
    logic [31:0]      Vj;
    logic [31:0]      Vk;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [3:0]       opcode;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    ent_t m_rs [RS_SZ];
    bit   m_run;
    pkt_t m_out;
    pkt_t exp_q [$];

    alu_rs #(.RS_SZ(RS_SZ), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .issue_flg(issue_flg), .issue_opcode(issue_opcode), .issue_rd(issue_rd),
        .issue_Qj_busy(issue_Qj_busy), .issue_Qk_busy(issue_Qk_busy),
        .issue_Qj(issue_Qj), .issue_Qk(issue_Qk), .issue_Vj(issue_Vj),
        .issue_Vk(issue_Vk), .issue_imm(issue_imm), .issue_pc(issue_pc),
        .alu_cdb_flg(alu_cdb_flg), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_flg(lsb_cdb_flg), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
        .rs_full(rs_full), .run_flg(run_flg), .rd_fr(rd_fr), .Vj(Vj), .Vk(Vk),
        .imm(imm), .pc(pc), .opcode(opcode)
    );

    // ---------------- clock / reset ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        rdy_in        = 1'b1;
        clr_in        = 1'b0;
        issue_flg     = 1'b0;
        issue_opcode  = '0;
        issue_rd      = '0;
        issue_Qj_busy = 1'b0;
        issue_Qk_busy = 1'b0;
        issue_Qj      = '0;
        issue_Qk      = '0;
        issue_Vj      = '0;
        issue_Vk      = '0;
        issue_imm     = '0;
        issue_pc      = '0;
        alu_cdb_flg   = 1'b0;
        alu_cdb_tag   = '0;
        alu_cdb_val   = '0;
        lsb_cdb_flg   = 1'b0;
        lsb_cdb_tag   = '0;
        lsb_cdb_val   = '0;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic [TAG_W-1:0] rd,
                             input logic jb, input logic [TAG_W-1:0] qj, input logic [31:0] vj,
                             input logic kb, input logic [TAG_W-1:0] qk, input logic [31:0] vk,
                             input logic [31:0] im, input logic [31:0] p);
        issue_flg     = 1'b1;
        issue_opcode  = op;
        issue_rd      = rd;
        issue_Qj_busy = jb;
        issue_Qj      = qj;
        issue_Vj      = vj;
        issue_Qk_busy = kb;
        issue_Qk      = qk;
        issue_Vk      = vk;
        issue_imm     = im;
        issue_pc      = p;
    endtask

    task automatic pulse_reset();
        drive_idle();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    function automatic pkt_t dut_pkt();
        return {rd_fr, opcode, Vj, Vk, imm, pc};
    endfunction

    // ---------------- reference model ----------------
    function automatic bit alu_hit(input logic [TAG_W-1:0] t);
        return alu_cdb_flg && alu_cdb_tag == t;
    endfunction

    function automatic bit lsb_hit(input logic [TAG_W-1:0] t);
        return lsb_cdb_flg && lsb_cdb_tag == t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SZ; i++) m_rs[i].busy = 1'b0;
        m_run = 1'b0;
        m_out = '0;
        exp_q.delete();
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < RS_SZ; i++) if (m_rs[i].busy) n++;
        return n;
    endfunction

    // One clock edge of the station, judged on the state before the edge.
    task automatic model_step(output bit pushed);
        ent_t old [RS_SZ];
        ent_t e;
        int d;
        int f;
        pushed = 1'b0;
        if (!rdy_in) return;
        if (clr_in) begin
            for (int i = 0; i < RS_SZ; i++) m_rs[i].busy = 1'b0;
            m_run = 1'b0;
            return;
        end
        old = m_rs;
        d = -1;
        f = -1;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (old[i].busy && !old[i].jb && !old[i].kb) d = i;
            if (!old[i].busy) f = i;
        end
        for (int i = 0; i < RS_SZ; i++) begin
            if (old[i].busy && old[i].jb) begin
                if (alu_hit(old[i].qj)) begin m_rs[i].jb = 0; m_rs[i].vj = alu_cdb_val; end
                else if (lsb_hit(old[i].qj)) begin m_rs[i].jb = 0; m_rs[i].vj = lsb_cdb_val; end
            end
            if (old[i].busy && old[i].kb) begin
                if (alu_hit(old[i].qk)) begin m_rs[i].kb = 0; m_rs[i].vk = alu_cdb_val; end
                else if (lsb_hit(old[i].qk)) begin m_rs[i].kb = 0; m_rs[i].vk = lsb_cdb_val; end
            end
        end
        if (d >= 0) begin
            m_run = 1'b1;
            m_out = {old[d].rd, old[d].op, old[d].vj, old[d].vk, old[d].imm, old[d].pc};
            m_rs[d].busy = 1'b0;
            exp_q.push_back(m_out);
            pushed = 1'b1;
        end else begin
            m_run = 1'b0;
        end
        if (issue_flg && f >= 0) begin
            e.busy = 1'b1; e.op = issue_opcode; e.rd = issue_rd; e.imm = issue_imm; e.pc = issue_pc;
            e.jb = issue_Qj_busy; e.qj = issue_Qj; e.vj = issue_Vj;
            e.kb = issue_Qk_busy; e.qk = issue_Qk; e.vk = issue_Vk;
            if (e.jb && alu_hit(e.qj)) begin e.jb = 0; e.vj = alu_cdb_val; end
            else if (e.jb && lsb_hit(e.qj)) begin e.jb = 0; e.vj = lsb_cdb_val; end
            if (e.kb && alu_hit(e.qk)) begin e.kb = 0; e.vk = alu_cdb_val; end
            else if (e.kb && lsb_hit(e.qk)) begin e.kb = 0; e.vk = lsb_cdb_val; end
            m_rs[f] = e;
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        drive_idle();
        rst_in = 1'b0;
        tick();
        tick();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL reset_run act=%0b exp=0", run_flg); end
        n_checks++; if (rs_full !== 1'b0) begin n_errors++; $display("FAIL reset_full act=%0b exp=0", rs_full); end
        n_checks++; if (dut_pkt() !== '0) begin n_errors++; $display("FAIL reset_outputs act=%h exp=0", dut_pkt()); end
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_idle();
        set_issue(4'h0, 5'd3, 0, 5'd0, 32'd5, 0, 5'd0, 32'd7, 32'h0, 32'h100);
        tick();
        drive_idle();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL basic_early act=%0b exp=0", run_flg); end
        tick();
        n_checks++; if (run_flg !== 1'b1) begin n_errors++; $display("FAIL basic_run act=%0b exp=1", run_flg); end
        n_checks++; if ({rd_fr, Vj, Vk, pc} !== {5'd3, 32'd5, 32'd7, 32'h100}) begin
            n_errors++; $display("FAIL basic_fields act=%0d/%0d/%0d/%h exp=3/5/7/100", rd_fr, Vj, Vk, pc); end
        tick();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL basic_once act=%0b exp=0", run_flg); end
        n_checks++; if (rs_full !== 1'b0) begin n_errors++; $display("FAIL basic_full act=%0b exp=0", rs_full); end
        n_checks++; if (rd_fr !== 5'd3) begin n_errors++; $display("FAIL basic_hold act=%0d exp=3", rd_fr); end
    endtask

    task automatic test_capture();
        drive_idle();
        set_issue(4'h1, 5'd4, 1, 5'd2, 32'h0, 0, 5'd0, 32'd9, 32'h0, 32'h200);
        tick();
        drive_idle();
        alu_cdb_flg = 1'b1; alu_cdb_tag = 5'd5; alu_cdb_val = 32'hDEAD;  // wrong tag
        tick();
        drive_idle();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL cap_wrong_tag act=%0b exp=0", run_flg); end
        alu_cdb_flg = 1'b1; alu_cdb_tag = 5'd2; alu_cdb_val = 32'h10;
        tick();
        drive_idle();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL cap_same_cycle act=%0b exp=0", run_flg); end
        tick();
        n_checks++; if ({run_flg, rd_fr, Vj, Vk} !== {1'b1, 5'd4, 32'h10, 32'd9}) begin
            n_errors++; $display("FAIL cap_dispatch act=%0b/%0d/%h/%0d exp=1/4/10/9", run_flg, rd_fr, Vj, Vk); end
        // both operands captured in one cycle, from different buses
        set_issue(4'h3, 5'd6, 1, 5'd3, 32'h0, 1, 5'd4, 32'h0, 32'h5, 32'h300);
        tick();
        drive_idle();
        alu_cdb_flg = 1'b1; alu_cdb_tag = 5'd3; alu_cdb_val = 32'h33;
        lsb_cdb_flg = 1'b1; lsb_cdb_tag = 5'd4; lsb_cdb_val = 32'h44;
        tick();
        drive_idle();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL cap2_early act=%0b exp=0", run_flg); end
        tick();
        n_checks++; if ({run_flg, rd_fr, opcode, Vj, Vk, imm} !== {1'b1, 5'd6, 4'h3, 32'h33, 32'h44, 32'h5}) begin
            n_errors++; $display("FAIL cap2_dispatch act=%0b/%0d/%h/%h/%h exp=1/6/3/33/44", run_flg, rd_fr, opcode, Vj, Vk); end
        tick();
    endtask

    task automatic test_bypass();
        drive_idle();
        set_issue(4'h2, 5'd5, 0, 5'd0, 32'd1, 1, 5'd6, 32'h0, 32'h0, 32'h400);
        lsb_cdb_flg = 1'b1; lsb_cdb_tag = 5'd6; lsb_cdb_val = 32'hAB;
        tick();
        drive_idle();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL byp_early act=%0b exp=0", run_flg); end
        tick();
        n_checks++; if ({run_flg, rd_fr, Vj, Vk} !== {1'b1, 5'd5, 32'd1, 32'hAB}) begin
            n_errors++; $display("FAIL byp_dispatch act=%0b/%0d/%0d/%h exp=1/5/1/ab", run_flg, rd_fr, Vj, Vk); end
        tick();
    endtask

    task automatic test_full();
        drive_idle();
        for (int i = 0; i < RS_SZ; i++) begin
            set_issue(4'h0, TAG_W'(8 + i), 1, 5'd1, 32'h0, 0, 5'd0, 32'(i), 32'h0, 32'(i));
            tick();
        end
        n_checks++; if (rs_full !== 1'b1) begin n_errors++; $display("FAIL full_set act=%0b exp=1", rs_full); end
        set_issue(4'h0, 5'd20, 0, 5'd0, 32'h9, 0, 5'd0, 32'h9, 32'h0, 32'h0);  // dropped
        tick();
        drive_idle();
        n_checks++; if ({rs_full, run_flg} !== 2'b10) begin n_errors++; $display("FAIL full_drop act=%b exp=10", {rs_full, run_flg}); end
        alu_cdb_flg = 1'b1; alu_cdb_tag = 5'd1; alu_cdb_val = 32'h55;
        tick();
        drive_idle();
        for (int i = 0; i < RS_SZ; i++) begin
            tick();
            n_checks++; if ({run_flg, rd_fr, Vj, Vk, rs_full} !== {1'b1, TAG_W'(8 + i), 32'h55, 32'(i), 1'b0}) begin
                n_errors++; $display("FAIL full_drain%0d act=%0b/%0d/%h/%0d/%0b exp=1/%0d/55/%0d/0", i, run_flg, rd_fr, Vj, Vk, rs_full, 8 + i, i); end
        end
        tick();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL full_no_ninth act=%0b exp=0", run_flg); end
    endtask

    task automatic test_clear();
        drive_idle();
        for (int i = 0; i < RS_SZ - 1; i++) begin
            set_issue(4'h0, TAG_W'(16 + i), 1, 5'd7, 32'h0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
            tick();
        end
        set_issue(4'h0, 5'd23, 0, 5'd0, 32'h77, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++; if ({rs_full, run_flg} !== 2'b10) begin n_errors++; $display("FAIL clr_pre act=%b exp=10", {rs_full, run_flg}); end
        set_issue(4'h0, 5'd24, 0, 5'd0, 32'h88, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        clr_in = 1'b1;
        tick();
        drive_idle();
        n_checks++; if ({rs_full, run_flg} !== 2'b00) begin n_errors++; $display("FAIL clr_flush act=%b exp=00", {rs_full, run_flg}); end
        alu_cdb_flg = 1'b1; alu_cdb_tag = 5'd7; alu_cdb_val = 32'h70;
        tick();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL clr_ghost%0d act=%0b exp=0", i, run_flg); end
        end
    endtask

    task automatic test_stall_reset();
        drive_idle();
        set_issue(4'h4, 5'd9, 0, 5'd0, 32'h11, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        drive_idle();
        rdy_in = 1'b0;
        set_issue(4'h4, 5'd10, 0, 5'd0, 32'h22, 0, 5'd0, 32'h0, 32'h0, 32'h0);  // ignored
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL stall_%0d act=%0b exp=0", i, run_flg); end
        end
        drive_idle();
        tick();
        n_checks++; if ({run_flg, rd_fr, Vj} !== {1'b1, 5'd9, 32'h11}) begin
            n_errors++; $display("FAIL stall_release act=%0b/%0d/%h exp=1/9/11", run_flg, rd_fr, Vj); end
        rdy_in = 1'b0;
        tick();
        n_checks++; if ({run_flg, rd_fr} !== {1'b1, 5'd9}) begin n_errors++; $display("FAIL stall_hold act=%0b/%0d exp=1/9", run_flg, rd_fr); end
        rdy_in = 1'b1;
        tick();
        n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL stall_dropped act=%0b exp=0", run_flg); end
        // reset in the middle of a run
        set_issue(4'h5, 5'd11, 0, 5'd0, 32'h1, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        set_issue(4'h5, 5'd12, 0, 5'd0, 32'h2, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        drive_idle();
        n_checks++; if ({run_flg, rd_fr} !== {1'b1, 5'd11}) begin n_errors++; $display("FAIL rst_pre act=%0b/%0d exp=1/11", run_flg, rd_fr); end
        #2;
        rst_in = 1'b0;
        #1;
        n_checks++; if ({run_flg, rs_full, rd_fr} !== {1'b0, 1'b0, 5'd0}) begin
            n_errors++; $display("FAIL rst_async act=%0b/%0b/%0d exp=0/0/0", run_flg, rs_full, rd_fr); end
        #1;
        rst_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (run_flg !== 1'b0) begin n_errors++; $display("FAIL rst_lost%0d act=%0b exp=0", i, run_flg); end
        end
    endtask

    task automatic rand_cycle(input bit drain, input int cyc);
        bit   pushed;
        pkt_t exp;
        drive_idle();
        if (drain) begin
            alu_cdb_flg = 1'b1; alu_cdb_tag = TAG_W'(cyc % 8); alu_cdb_val = $urandom;
            lsb_cdb_flg = 1'b1; lsb_cdb_tag = TAG_W'((cyc + 4) % 8); lsb_cdb_val = $urandom;
        end else begin
            rdy_in = ($urandom_range(0, 9) != 0);
            clr_in = ($urandom_range(0, 59) == 0);
            if (model_count() < RS_SZ && $urandom_range(0, 9) < 6) begin
                set_issue(4'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom,
                          $urandom, $urandom);
            end
            alu_cdb_flg = ($urandom_range(0, 2) == 0); alu_cdb_tag = TAG_W'($urandom_range(0, 7)); alu_cdb_val = $urandom;
            lsb_cdb_flg = ($urandom_range(0, 2) == 0); lsb_cdb_tag = TAG_W'($urandom_range(0, 7)); lsb_cdb_val = $urandom;
            if (alu_cdb_flg && lsb_cdb_flg && alu_cdb_tag == lsb_cdb_tag) lsb_cdb_flg = 1'b0;
        end
        model_step(pushed);
        tick();
        n_checks++; if (run_flg !== m_run) begin n_errors++; $display("FAIL rand_run cyc=%0d act=%0b exp=%0b", cyc, run_flg, m_run); end
        n_checks++; if (rs_full !== (model_count() == RS_SZ)) begin
            n_errors++; $display("FAIL rand_full cyc=%0d act=%0b exp=%0b", cyc, rs_full, model_count() == RS_SZ); end
        exp = pushed ? exp_q.pop_front() : m_out;
        n_checks++; if (dut_pkt() !== exp) begin n_errors++; $display("FAIL rand_pkt cyc=%0d act=%h exp=%h", cyc, dut_pkt(), exp); end
    endtask

    task automatic test_random();
        pulse_reset();
        model_reset();
        for (int c = 0; c < 500; c++) rand_cycle(1'b0, c);
        for (int c = 0; c < 40; c++) rand_cycle(1'b1, c);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_in = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_capture();
        test_bypass();
        test_full();
        test_clear();
        test_stall_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
